tap_controller: RTL

TAP_CONTROLLER -- requirements
Module: tap_controller

---
 rtl/tap_pkg.sv | 59 +++++
 rtl/tap_controller_if.sv | 29 ++
 rtl/tap_fsm.sv | 48 ++++
 rtl/tap_controller.sv | 115 +++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared TAP types: 16-state FSM encoding, instruction codes, DR selection decode.
// Macro TAP_IDCODE_EN enables the IDCODE data register; otherwise IDCODE decodes as BYPASS.
package tap_pkg;

  // IEEE 1149.1 suggested state encoding
  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RTI        = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TLR        = 4'hF
  } tap_state_e;

  typedef enum logic [3:0] {
    IR_EXTEST = 4'b0000,
    IR_SAMPLE = 4'b0001,
    IR_IDCODE = 4'b0010,
    IR_BYPASS = 4'b1111
  } tap_instr_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_CHAIN
  } dr_sel_e;

  localparam logic [3:0] IR_CAPTURE = 4'b0101;

`ifdef TAP_IDCODE_EN
  localparam logic [3:0] IR_RESET = IR_IDCODE;
`else
  localparam logic [3:0] IR_RESET = IR_BYPASS;
`endif

  // Unknown codes fall through to BYPASS so the chain length stays defined.
  function automatic dr_sel_e decode_dr(input logic [3:0] ir);
    dr_sel_e sel;
    case (ir)
      IR_EXTEST, IR_SAMPLE: sel = DR_CHAIN;
`ifdef TAP_IDCODE_EN
      IR_IDCODE:            sel = DR_IDCODE;
`endif
      default:              sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/tap_controller_if.sv
// JTAG pins and boundary-scan cell controls of the TAP controller.
// slave = the controller side, master = tester / scan-cell side.
interface tap_controller_if;
  logic       tms_i;
  logic       tdi_i;
  logic       tdo_o;
  logic       tdo_en_o;
  logic       bs_si_o;
  logic       bs_so_i;
  logic       SAMPLE_o;
  logic       PRELOAD_o;
  logic       clockDR_o;
  logic       shiftDR_o;
  logic       updateDR_o;
  logic       mode_o;
  logic [3:0] state_o;

  modport slave (
    input  tms_i, tdi_i, bs_so_i,
    output tdo_o, tdo_en_o, bs_si_o, SAMPLE_o, PRELOAD_o,
           clockDR_o, shiftDR_o, updateDR_o, mode_o, state_o
  );

  modport master (
    output tms_i, tdi_i, bs_so_i,
    input  tdo_o, tdo_en_o, bs_si_o, SAMPLE_o, PRELOAD_o,
           clockDR_o, shiftDR_o, updateDR_o, mode_o, state_o
  );
endinterface

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine; advances on every tck rising edge.
// state_next_o is exposed so the controller can act on TLR entry.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output tap_state_e state_next_o
);

  tap_state_e state_q, state_d;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      TLR:        state_d = tms_i ? TLR       : RTI;
      RTI:        state_d = tms_i ? SELECT_DR : RTI;
      SELECT_DR:  state_d = tms_i ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: state_d = tms_i ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   state_d = tms_i ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   state_d = tms_i ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   state_d = tms_i ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   state_d = tms_i ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  state_d = tms_i ? SELECT_DR : RTI;
      SELECT_IR:  state_d = tms_i ? TLR       : CAPTURE_IR;
      CAPTURE_IR: state_d = tms_i ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   state_d = tms_i ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   state_d = tms_i ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   state_d = tms_i ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   state_d = tms_i ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  state_d = tms_i ? SELECT_DR : RTI;
      default:    state_d = TLR;
    endcase
  end

  // NOTE: reset is synchronous (sampled at the edge) and state uses non-blocking assignment.
  always_ff @(posedge tck_i) begin
    if (trst_i) state_q <= TLR;
    else        state_q <= state_d;
  end

  assign state_o      = state_q;
  assign state_next_o = trst_i ? TLR : state_d;

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: IR, BYPASS / IDCODE data registers, decode, TDO mux, cell controls.
// Define TAP_IDCODE_EN to include the 32-bit IDCODE register.
module tap_controller
  import tap_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
  parameter int          IR_W         = 4
) (
  input logic              tck_i,
  input logic              trst_i,
  tap_controller_if.slave  tap
);

  tap_state_e state, state_next;

  tap_fsm u_fsm (
    .tck_i        (tck_i),
    .trst_i       (trst_i),
    .tms_i        (tap.tms_i),
    .state_o      (state),
    .state_next_o (state_next)
  );

  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] ir_shift_q, ir_shift_d;
  logic            bypass_q, bypass_d;
  dr_sel_e         dr_sel;

  assign dr_sel = decode_dr(ir_q);

  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    bypass_d   = bypass_q;
    unique case (state)
      CAPTURE_IR: ir_shift_d = IR_CAPTURE;
      SHIFT_IR:   ir_shift_d = {tap.tdi_i, ir_shift_q[IR_W-1:1]};
      UPDATE_IR:  ir_d       = ir_shift_q;
      CAPTURE_DR: bypass_d   = 1'b0;
      SHIFT_DR:   bypass_d   = tap.tdi_i;
      default:    ;
    endcase
    // Reloading on TLR entry means IR already holds the reset code throughout TLR.
    if (state_next == TLR) ir_d = IR_RESET;
  end

  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      ir_q       <= IR_RESET;
      ir_shift_q <= '0;
      bypass_q   <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_q, idcode_d;

  always_comb begin
    idcode_d = idcode_q;
    if (state == CAPTURE_DR)
      idcode_d = IDCODE_VALUE;
    else if (state == SHIFT_DR && dr_sel == DR_IDCODE)
      idcode_d = {tap.tdi_i, idcode_q[31:1]};
  end

  always_ff @(posedge tck_i) begin
    if (trst_i) idcode_q <= IDCODE_VALUE;
    else        idcode_q <= idcode_d;
  end
`else
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VALUE;
`endif

  logic tdo, tdo_en;

  always_comb begin
    tdo    = 1'b0;
    tdo_en = 1'b0;
    if (state == SHIFT_IR) begin
      tdo_en = 1'b1;
      tdo    = ir_shift_q[0];
    end else if (state == SHIFT_DR) begin
      tdo_en = 1'b1;
      unique case (dr_sel)
        DR_CHAIN:  tdo = tap.bs_so_i;
`ifdef TAP_IDCODE_EN
        DR_IDCODE: tdo = idcode_q[0];
`endif
        default:   tdo = bypass_q;
      endcase
    end
  end

  // Cell controls depend only on registered state/IR (plus reset), never on tms/tdi.
  logic cells_live, chain_sel;
  assign cells_live = !trst_i && (state != TLR);
  assign chain_sel  = cells_live && (dr_sel == DR_CHAIN);

  assign tap.tdo_o      = tdo;
  assign tap.tdo_en_o   = tdo_en;
  assign tap.bs_si_o    = tap.tdi_i;
  assign tap.SAMPLE_o   = chain_sel;
  assign tap.PRELOAD_o  = cells_live && (ir_q == IR_SAMPLE);
  assign tap.mode_o     = cells_live && (ir_q == IR_EXTEST);
  assign tap.clockDR_o  = chain_sel && (state == CAPTURE_DR || state == SHIFT_DR);
  assign tap.shiftDR_o  = chain_sel && (state == SHIFT_DR);
  assign tap.updateDR_o = chain_sel && (state == UPDATE_DR);
  assign tap.state_o    = state;

endmodule
